// File: rtl/fsb8_if.sv
// FSB8 multiplexed bus as seen by the peripheral-side target.
// The master modport drives strobes and the AD/AAH8 lines; the slave answers.
interface fsb8_if;
  logic       ale_n;
  logic       cs_n;
  logic       cmd_n;
  logic       typ;
  logic       wr_n;
  logic [7:0] AAH8;
  logic [7:0] AD_in;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic       rdy_n;
  logic       irq_n;

  modport master (
    output ale_n, cs_n, cmd_n, typ, wr_n, AAH8, AD_in,
    input  AD_out, AD_oe, rdy_n, irq_n
  );

  modport slave (
    input  ale_n, cs_n, cmd_n, typ, wr_n, AAH8, AD_in,
    output AD_out, AD_oe, rdy_n, irq_n
  );
endinterface

// File: rtl/fsb8_target.sv
// FSB8 bus target: decodes command/address/data frames, runs one local
// request/ack transfer at a time, and returns data, ready and irq_n to the master.
module fsb8_target #(
  parameter bit         PAE_ENABLE = 1'b0,
  parameter int         ADDR_WIDTH = PAE_ENABLE ? 32 : 24,
  parameter int         IRQ_NUM    = 4,
  parameter logic [7:0] TIMEOUT    = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst,
  fsb8_if.slave                 bus,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  output logic [7:0]            cmd_data,
  output logic [7:0]            cmd_arg,
  output logic                  cmd_valid,
  input  logic [IRQ_NUM-1:0]    irq_src,
  input  logic [IRQ_NUM-1:0]    irq_en,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RESP} state_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_t      state, state_nxt;
  logic [7:0]  h8;
  logic [15:0] m16;
  logic [7:0]  tmo_cnt;
  logic [31:0] full_addr;
  logic        idle, in_req, ack_hit, tmo_hit;
  logic        cmd_hit, ale_hit, cs_hit, strobe_any;

  assign idle    = (state == IDLE);
  assign in_req  = (state == WR_REQ) || (state == RD_REQ);
  assign ack_hit = in_req && mem_ack;
  assign tmo_hit = in_req && !mem_ack && (tmo_cnt == TIMEOUT - 8'd1);

  // Strobe priority: cmd_n over ale_n over cs_n, and only while idle.
  assign cmd_hit    = idle && !bus.cmd_n;
  assign ale_hit    = idle && bus.cmd_n && !bus.ale_n;
  assign cs_hit     = idle && bus.cmd_n && bus.ale_n && !bus.cs_n;
  assign strobe_any = !bus.cmd_n || !bus.ale_n || !bus.cs_n;
  assign full_addr  = {h8, m16, bus.AAH8};

  // mem_req is gated by rst so a reset abandons the transfer immediately.
  assign mem_req    = in_req && !rst;
  assign busy       = !idle;
  assign bus.rdy_n  = (state != RESP);
  assign bus.AD_oe  = (state == RESP) && !mem_we;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:           if (cs_hit) state_nxt = bus.wr_n ? RD_REQ : WR_REQ;
      WR_REQ, RD_REQ: if (ack_hit || tmo_hit) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      h8         <= '0;
      m16        <= '0;
      tmo_cnt    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cmd_data   <= '0;
      cmd_arg    <= '0;
      cmd_valid  <= 1'b0;
      err        <= 1'b0;
      bus.AD_out <= '0;
      bus.irq_n  <= 1'b1;
    end else begin
      cmd_valid <= 1'b0;
      bus.irq_n <= ~|(irq_src & irq_en);

      if (cmd_hit) begin
        if (bus.AD_in == 8'h00) begin
          if (PAE_ENABLE) h8 <= bus.AAH8;
        end else begin
          cmd_data  <= bus.AD_in;
          cmd_arg   <= bus.AAH8;
          cmd_valid <= 1'b1;
        end
      end

      if (ale_hit) m16 <= {bus.AAH8, bus.AD_in};

      if (cs_hit) begin
        mem_addr <= addr_t'(full_addr);
        if (!bus.wr_n) begin
          mem_wdata <= bus.AD_in;
          mem_we    <= 1'b1;
        end else begin
          mem_we    <= 1'b0;
        end
      end

      if (in_req && !ack_hit && !tmo_hit) tmo_cnt <= tmo_cnt + 8'd1;
      else                                tmo_cnt <= '0;

      if (state == RD_REQ) begin
        if (ack_hit)      bus.AD_out <= mem_rdata;
        else if (tmo_hit) bus.AD_out <= 8'hFF;
      end

      // A new error outranks a simultaneous clear.
      if (tmo_hit || (busy && strobe_any)) err <= 1'b1;
      else if (err_clr)                    err <= 1'b0;
    end
  end

endmodule
